xg_video_timing: RTL and testbench

Parametrised raster timing and render-sequencing generator for the XenonGecko video path. It runs in the pixel clock domain and produces the beam counters, render and draw area flags, and delayed sync signals for the TMDS encoder. It also issues the pattern/attribute buffer swap strobes and the attribute row base consumed by the memory-fetch unit. Any resolution, tile height, row stride and render-to-draw pipeline depth can be built from one RTL source.

---
 rtl/xg_pkg.sv | 29 ++
 rtl/xg_delay_line.sv | 31 +++
 rtl/xg_video_timing.sv | 187 ++++++++++++++++++
 tb/tb_xg_video_timing.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xg_pkg.sv
// Shared XenonGecko video definitions: 640x480@60 raster defaults, TMDS
// control codes and the beam position type.
package xg_pkg;

  localparam int XG_H_ACTIVE   = 640;
  localparam int XG_H_FP       = 16;
  localparam int XG_H_SYNC     = 96;
  localparam int XG_H_BP       = 48;
  localparam int XG_V_ACTIVE   = 480;
  localparam int XG_V_FP       = 10;
  localparam int XG_V_SYNC     = 2;
  localparam int XG_V_BP       = 33;
  localparam int XG_DRAW_DELAY = 8;
  localparam int XG_TILE_H     = 8;
  localparam int XG_ROW_STRIDE = 80;
  localparam int XG_BASE_W     = 13;

  // Control-period symbols sent by the TMDS encoder, indexed by {c1, c0}.
  localparam logic [9:0] XG_TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] XG_TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] XG_TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] XG_TMDS_CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] line;
  } xg_beam_t;

endpackage

// File: rtl/xg_delay_line.sv
// Reset-clearable shift register: data_o is data_i delayed DEPTH cycles.
module xg_delay_line
  import xg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_25) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/xg_video_timing.sv
// Raster timing and render sequencing for the XenonGecko video path.
// Optional line interrupt is built when XG_TIMING_LINE_IRQ_EN is defined.
module xg_video_timing
  import xg_pkg::*;
#(
  parameter int   H_ACTIVE   = XG_H_ACTIVE,
  parameter int   H_FP       = XG_H_FP,
  parameter int   H_SYNC     = XG_H_SYNC,
  parameter int   H_BP       = XG_H_BP,
  parameter int   V_ACTIVE   = XG_V_ACTIVE,
  parameter int   V_FP       = XG_V_FP,
  parameter int   V_SYNC     = XG_V_SYNC,
  parameter int   V_BP       = XG_V_BP,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   DRAW_DELAY = XG_DRAW_DELAY,
  parameter int   TILE_H     = XG_TILE_H,
  parameter int   ROW_STRIDE = XG_ROW_STRIDE,
  parameter int   BASE_W     = XG_BASE_W,
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  CW         = $clog2(H_TOTAL),
  localparam int  LW         = $clog2(V_TOTAL),
  localparam int  TW         = $clog2(TILE_H)
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic [BASE_W-1:0] frame_base,
`ifdef XG_TIMING_LINE_IRQ_EN
  input  logic [LW-1:0]     line_cmp,
  input  logic              irq_ack,
  output logic              line_irq,
`endif
  output logic [CW-1:0]     col,
  output logic [LW-1:0]     line,
  output logic              render_area,
  output logic              draw_area,
  output logic              vde,
  output logic              draw_hsync,
  output logic              draw_vsync,
  output logic              swap_pattern,
  output logic              swap_attribute,
  output logic [BASE_W-1:0] next_row_base,
  output logic [TW-2:0]     next_line_pair,
  output logic              frame_start
);

  localparam logic [CW-1:0]     COL_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]     COL_ACT   = CW'(H_ACTIVE);
  localparam logic [LW-1:0]     LINE_LAST = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0]     LINE_ACT  = LW'(V_ACTIVE);
  localparam logic [CW:0]       HS_START  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]       HS_STOP   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [LW:0]       VS_START  = (LW+1)'(V_ACTIVE + V_FP);
  localparam logic [LW:0]       VS_STOP   = (LW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TW-1:0]     TILE_LAST = TW'(TILE_H - 1);
  localparam logic [BASE_W-1:0] STRIDE    = BASE_W'(ROW_STRIDE);

  logic [CW-1:0]     col_q, col_d;
  logic [LW-1:0]     line_q, line_d;
  logic              render_q, render_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              swap_pattern_q, swap_pattern_d;
  logic              swap_attribute_q, swap_attribute_d;
  logic              frame_start_q, frame_start_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              vde_q;
  logic              line_end_d, frame_last_d, line_vis_d, frame_wrap;
  logic [2:0]        dly_in, dly_out;

  always_comb begin
    col_d  = col_q + 1'b1;
    line_d = line_q;
    if (col_q == COL_LAST) begin
      col_d  = '0;
      line_d = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
    end
  end

  assign frame_wrap = (col_q == COL_LAST) && (line_q == LINE_LAST);

  // Area and strobe flags are computed from the next beam position so that the
  // registered copies line up with the counters they describe.
  always_comb begin
    line_end_d       = (col_d == COL_LAST);
    frame_last_d     = (line_d == LINE_LAST);
    line_vis_d       = (line_d < LINE_ACT);
    render_d         = (col_d < COL_ACT) && line_vis_d;
    hsync_d          = ({1'b0, col_q} >= HS_START) && ({1'b0, col_q} < HS_STOP);
    vsync_d          = ({1'b0, line_q} >= VS_START) && ({1'b0, line_q} < VS_STOP);
    swap_pattern_d   = line_end_d && ((line_vis_d && line_d[0]) || frame_last_d);
    swap_attribute_d = line_end_d &&
                       ((line_vis_d && (line_d[TW-1:0] == TILE_LAST)) || frame_last_d);
    frame_start_d    = (col_d == '0) && (line_d == '0);
    base_d           = base_q;
    if (swap_attribute_q) begin
      base_d = base_q + STRIDE;
    end
    if (frame_wrap) begin
      base_d = frame_base;
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      col_q            <= '0;
      line_q           <= '0;
      render_q         <= 1'b1;
      hsync_q          <= 1'b0;
      vsync_q          <= 1'b0;
      swap_pattern_q   <= 1'b0;
      swap_attribute_q <= 1'b0;
      frame_start_q    <= 1'b0;
      base_q           <= '0;
    end else begin
      col_q            <= col_d;
      line_q           <= line_d;
      render_q         <= render_d;
      hsync_q          <= hsync_d;
      vsync_q          <= vsync_d;
      swap_pattern_q   <= swap_pattern_d;
      swap_attribute_q <= swap_attribute_d;
      frame_start_q    <= frame_start_d;
      base_q           <= base_d;
    end
  end

  // Syncs travel active-high through the pipeline and take their polarity at the output.
  assign dly_in = {render_q, hsync_q, vsync_q};

  xg_delay_line #(
    .WIDTH (3),
    .DEPTH (DRAW_DELAY)
  ) u_draw_dly (
    .clk_25 (clk_25),
    .rst    (rst),
    .data_i (dly_in),
    .data_o (dly_out)
  );

  always_ff @(posedge clk_25) begin
    if (rst) begin
      vde_q <= 1'b0;
    end else begin
      vde_q <= dly_out[2];
    end
  end

`ifdef XG_TIMING_LINE_IRQ_EN
  logic line_irq_q, line_irq_d;

  always_comb begin
    line_irq_d = line_irq_q;
    if (irq_ack) begin
      line_irq_d = 1'b0;
    end
    if ((col_q == COL_ACT) && (line_q == line_cmp)) begin
      line_irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      line_irq_q <= 1'b0;
    end else begin
      line_irq_q <= line_irq_d;
    end
  end

  assign line_irq = line_irq_q;
`endif

  assign col            = col_q;
  assign line           = line_q;
  assign render_area    = render_q;
  assign draw_area      = dly_out[2];
  assign vde            = vde_q;
  assign draw_hsync     = dly_out[1] ^ ~HSYNC_POL;
  assign draw_vsync     = dly_out[0] ^ ~VSYNC_POL;
  assign swap_pattern   = swap_pattern_q;
  assign swap_attribute = swap_attribute_q;
  assign next_row_base  = base_q;
  assign next_line_pair = line_q[TW-1:1] + 1'b1;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_xg_video_timing.sv
// Directed bench for xg_video_timing on a reduced 24x38 raster (16x32 visible)
// so several whole frames fit in a short run.
module tb_xg_video_timing;

  localparam int H_ACTIVE   = 16;
  localparam int H_FP       = 2;
  localparam int H_SYNC     = 4;
  localparam int H_BP       = 2;
  localparam int V_ACTIVE   = 32;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 2;
  localparam int H_TOTAL    = 24;
  localparam int V_TOTAL    = 38;
  localparam int FRAME      = H_TOTAL * V_TOTAL;
  localparam int DRAW_DELAY = 8;
  localparam int TILE_H     = 8;
  localparam int ROW_STRIDE = 80;
  localparam int BASE_W     = 13;
  localparam int CW         = 5;
  localparam int LW         = 6;
  localparam int TW         = 3;

  logic              clk_25 = 1'b0;
  logic              rst    = 1'b1;
  logic [BASE_W-1:0] frame_base = 13'h100;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line;
  logic              render_area, draw_area, vde, draw_hsync, draw_vsync;
  logic              swap_pattern, swap_attribute, frame_start;
  logic [BASE_W-1:0] next_row_base;
  logic [TW-2:0]     next_line_pair;
`ifdef XG_TIMING_LINE_IRQ_EN
  logic [LW-1:0]     line_cmp = 6'd63;
  logic              irq_ack  = 1'b0;
  logic              line_irq;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sp_cnt, sa_cnt, both_cnt, fs_cnt;
  int off_cnt   = 0;
  int beam_err  = 0;
  int draw_err  = 0;
  logic pend_base = 1'b0;
  logic [BASE_W-1:0] exp_q[$];

  // clock / reset
  always #20 clk_25 = ~clk_25;

  xg_video_timing #(
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .HSYNC_POL  (1'b0),
    .VSYNC_POL  (1'b1),
    .DRAW_DELAY (DRAW_DELAY),
    .TILE_H     (TILE_H),
    .ROW_STRIDE (ROW_STRIDE),
    .BASE_W     (BASE_W)
  ) dut (
    .clk_25         (clk_25),
    .rst            (rst),
    .frame_base     (frame_base),
`ifdef XG_TIMING_LINE_IRQ_EN
    .line_cmp       (line_cmp),
    .irq_ack        (irq_ack),
    .line_irq       (line_irq),
`endif
    .col            (col),
    .line           (line),
    .render_area    (render_area),
    .draw_area      (draw_area),
    .vde            (vde),
    .draw_hsync     (draw_hsync),
    .draw_vsync     (draw_vsync),
    .swap_pattern   (swap_pattern),
    .swap_attribute (swap_attribute),
    .next_row_base  (next_row_base),
    .next_line_pair (next_line_pair),
    .frame_start    (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
    cyc++;
  endtask

  function automatic logic active_at(input int k);
    return ((k % H_TOTAL) < H_ACTIVE) && (((k / H_TOTAL) % V_TOTAL) < V_ACTIVE);
  endfunction

  // Scoreboard: beam/draw outputs against a cycle-index model, strobe
  // counting, and next_row_base checked one cycle after each attribute swap.
  task automatic monitor();
    int c, l, d, dl;
    logic hs_on, vs_on;
    c = cyc % H_TOTAL;
    l = (cyc / H_TOTAL) % V_TOTAL;
    if (col !== CW'(c) || line !== LW'(l) || next_line_pair !== 2'(((l >> 1) + 1) % 4))
      beam_err++;
    if (render_area !== active_at(cyc)) draw_err++;
    if (draw_area !== ((cyc >= DRAW_DELAY) && active_at(cyc - DRAW_DELAY))) draw_err++;
    d     = cyc - DRAW_DELAY - 1;
    dl    = (d / H_TOTAL) % V_TOTAL;
    hs_on = (d >= 0) && ((d % H_TOTAL) >= H_ACTIVE + H_FP) &&
            ((d % H_TOTAL) < H_ACTIVE + H_FP + H_SYNC);
    vs_on = (d >= 0) && (dl >= V_ACTIVE + V_FP) && (dl < V_ACTIVE + V_FP + V_SYNC);
    if (vde !== ((d >= 0) && active_at(d))) draw_err++;
    if (draw_hsync !== ~hs_on) draw_err++;
    if (draw_vsync !== vs_on) draw_err++;
    if (swap_pattern) begin
      sp_cnt++;
      if (c != H_TOTAL - 1) off_cnt++;
    end
    if (swap_attribute) begin
      sa_cnt++;
      if (c != H_TOTAL - 1) off_cnt++;
    end
    if (swap_pattern && swap_attribute) both_cnt++;
    if (frame_start) begin
      fs_cnt++;
      if (c != 0 || l != 0 || render_area !== 1'b1) off_cnt++;
    end
    if (pend_base) begin
      if (exp_q.size() == 0) check("row_base_unexpected_swap", exp_q.size(), 1);
      else check("row_base", 32'(next_row_base), 32'(exp_q.pop_front()));
      pend_base = 1'b0;
    end
    if (swap_attribute) pend_base = 1'b1;
  endtask

  initial begin
    int found;
    exp_q = '{13'h050, 13'h0A0, 13'h0F0, 13'h140, 13'h100,
              13'h150, 13'h1A0, 13'h1F0, 13'h240, 13'h100,
              13'h150, 13'h1A0, 13'h1F0, 13'h240, 13'h1FF0, 13'h040};

    // reset state
    repeat (3) tick();
    check("rst_col", 32'(col), 0);
    check("rst_line", 32'(line), 0);
    check("rst_render", 32'(render_area), 1);
    check("rst_draw_area", 32'(draw_area), 0);
    check("rst_vde", 32'(vde), 0);
    check("rst_hsync", 32'(draw_hsync), 1);
    check("rst_vsync", 32'(draw_vsync), 0);
    check("rst_swap_pat", 32'(swap_pattern), 0);
    check("rst_swap_attr", 32'(swap_attribute), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_row_base", 32'(next_row_base), 0);
    check("rst_line_pair", 32'(next_line_pair), 1);
`ifdef XG_TIMING_LINE_IRQ_EN
    check("rst_line_irq", 32'(line_irq), 0);
`endif
    rst = 1'b0;
    cyc = 0;

    // draw pipeline latency from the first active pixel
    repeat (7) tick();
    check("draw_area_lag7", 32'(draw_area), 0);
    tick();
    check("draw_area_lag8", 32'(draw_area), 1);
    check("vde_lag8", 32'(vde), 0);
    tick();
    check("vde_lag9", 32'(vde), 1);
    check("col_after9", 32'(col), 9);

    // hsync pulse: low 9 cycles after col reaches the sync start, 4 wide
    found = 0;
    for (int i = 0; i < 48 && found == 0; i++) begin
      if (col == CW'(H_ACTIVE + H_FP)) found = 1;
      else tick();
    end
    check("hsync_start_found", found, 1);
    repeat (8) tick();
    check("hsync_before", 32'(draw_hsync), 1);
    tick();
    check("hsync_first", 32'(draw_hsync), 0);
    repeat (3) tick();
    check("hsync_last", 32'(draw_hsync), 0);
    tick();
    check("hsync_after", 32'(draw_hsync), 1);

    // three frames plus the first tile row of the fourth
    sp_cnt = 0; sa_cnt = 0; both_cnt = 0; fs_cnt = 0;
    while (cyc < 3 * FRAME + 8 * H_TOTAL + 1) begin
      if (cyc % FRAME == 0) begin
        if (cyc >= 2 * FRAME) begin
          check("swap_pattern_per_frame", sp_cnt, 17);
          check("swap_attribute_per_frame", sa_cnt, 5);
          check("swap_both_per_frame", both_cnt, 5);
          check("frame_start_per_frame", fs_cnt, 1);
        end
        sp_cnt = 0; sa_cnt = 0; both_cnt = 0; fs_cnt = 0;
      end
      if (cyc == 2 * FRAME + 100) frame_base = 13'h1FF0;
      monitor();
      tick();
    end
    check("row_base_queue_drained", exp_q.size(), 0);
    check("beam_track_errors", beam_err, 0);
    check("draw_track_errors", draw_err, 0);
    check("misplaced_strobes", off_cnt, 0);

    // reset just before a coinciding swap pair
    while (cyc < 3 * FRAME + 31 * H_TOTAL + 22) tick();
    check("pre_rst_col", 32'(col), 22);
    check("pre_rst_line", 32'(line), 31);
    check("pre_rst_vde", 32'(vde), 1);
    rst = 1'b1;
    tick();
    check("midrst_col", 32'(col), 0);
    check("midrst_line", 32'(line), 0);
    check("midrst_vde", 32'(vde), 0);
    check("midrst_draw_area", 32'(draw_area), 0);
    check("midrst_swap_pat", 32'(swap_pattern), 0);
    check("midrst_swap_attr", 32'(swap_attribute), 0);
    check("midrst_frame_start", 32'(frame_start), 0);
    check("midrst_row_base", 32'(next_row_base), 0);
    check("midrst_render", 32'(render_area), 1);
    tick();
    rst = 1'b0;
    cyc = 0;

`ifdef XG_TIMING_LINE_IRQ_EN
    check("irq_after_rst", 32'(line_irq), 0);
    line_cmp = 6'd10;
    while (cyc < 10 * H_TOTAL + H_ACTIVE) tick();
    check("irq_before_set", 32'(line_irq), 0);
    irq_ack = 1'b1;
    tick();
    check("irq_set_beats_ack", 32'(line_irq), 1);
    irq_ack = 1'b0;
    repeat (5) tick();
    check("irq_sticky", 32'(line_irq), 1);
    irq_ack = 1'b1;
    tick();
    check("irq_cleared", 32'(line_irq), 0);
    irq_ack = 1'b0;
    tick();
    check("irq_stays_clear", 32'(line_irq), 0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
